// File: rtl/j_img_pkg.sv
// Shared image-buffer definitions: dimension widths, block geometry and scan states.
package j_img_pkg;

   localparam int DIM_W     = 13;
   localparam int BLK       = 8;
   localparam int BLK_LOG2  = $clog2(BLK);
   localparam int BLK_CNT_W = DIM_W - BLK_LOG2;

   typedef logic [DIM_W-1:0] dim_t;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } scan_state_t;

   // Number of blocks covering d pixels, minus one; d must be nonzero.
   function automatic logic [BLK_CNT_W-1:0] blocks_m1(input dim_t d);
      logic [DIM_W:0] s;
      s = {1'b0, d} + (DIM_W+1)'(BLK - 1);
      s = s >> BLK_LOG2;
      return BLK_CNT_W'(s - 1'b1);
   endfunction

endpackage

// File: rtl/j_scan_counter.sv
// Enable/sync-clear counter with runtime rollover value; wrap flags the enabled cycle at max_val.
module j_scan_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         en,
   input  logic [W-1:0] max_val,
   output logic [W-1:0] count,
   output logic         wrap
);

   assign wrap = en && (count == max_val);

   always_ff @(posedge clk) begin
      if (clear)
         count <= '0;
      else if (en)
         count <= wrap ? '0 : count + 1'b1;
   end

endmodule

// File: rtl/j_block_scan_addr.sv
// Walks a raster-stored image in 8x8 block order, emitting one clamped (row, col) per handshake.
//
//   state | meaning
//   IDLE  | waiting for start with nonzero dimensions
//   SCAN  | presenting addresses, advancing on addr_valid && addr_ready
//   DONE  | one-cycle frame_done pulse, then back to IDLE
module j_block_scan_addr
   import j_img_pkg::*;
(
   input  logic             clk,
   input  logic             clear,
   input  logic             start,
   input  logic [DIM_W-1:0] img_width,
   input  logic [DIM_W-1:0] img_height,
   input  logic             addr_ready,
   output logic             addr_valid,
   output logic [DIM_W-1:0] row,
   output logic [DIM_W-1:0] col,
   output logic             last_in_block,
   output logic             last_in_frame,
   output logic             frame_done,
   output logic             busy
);

   localparam logic [BLK_LOG2-1:0] PIX_MAX = BLK_LOG2'(BLK - 1);

   scan_state_t state, state_nxt;
   logic        start_acc;
   logic        cnt_clear;
   logic        adv;

   dim_t                 w_lat, h_lat;
   logic [BLK_CNT_W-1:0] nbx_m1, nby_m1;

   logic [BLK_LOG2-1:0]  px_cnt, py_cnt;
   logic [BLK_CNT_W-1:0] bx_cnt, by_cnt;
   logic                 px_wrap, py_wrap, bx_wrap, by_wrap;

   dim_t raw_r, raw_c, w_m1, h_m1;

   always_ff @(posedge clk) begin
      if (clear)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_acc = 1'b0;
      case (state)
         IDLE: begin
            if (start && (img_width != '0) && (img_height != '0)) begin
               start_acc = 1'b1;
               state_nxt = SCAN;
            end
         end
         SCAN:    if (by_wrap) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Block counts are derived once here so the scan never sees live dimension inputs.
   always_ff @(posedge clk) begin
      if (clear) begin
         w_lat  <= '0;
         h_lat  <= '0;
         nbx_m1 <= '0;
         nby_m1 <= '0;
      end else if (start_acc) begin
         w_lat  <= img_width;
         h_lat  <= img_height;
         nbx_m1 <= blocks_m1(img_width);
         nby_m1 <= blocks_m1(img_height);
      end
   end

   assign adv       = (state == SCAN) && addr_ready;
   assign cnt_clear = clear || start_acc;

   j_scan_counter #(.W(BLK_LOG2)) u_px (
      .clk(clk), .clear(cnt_clear), .en(adv),     .max_val(PIX_MAX),
      .count(px_cnt), .wrap(px_wrap)
   );
   j_scan_counter #(.W(BLK_LOG2)) u_py (
      .clk(clk), .clear(cnt_clear), .en(px_wrap), .max_val(PIX_MAX),
      .count(py_cnt), .wrap(py_wrap)
   );
   j_scan_counter #(.W(BLK_CNT_W)) u_bx (
      .clk(clk), .clear(cnt_clear), .en(py_wrap), .max_val(nbx_m1),
      .count(bx_cnt), .wrap(bx_wrap)
   );
   j_scan_counter #(.W(BLK_CNT_W)) u_by (
      .clk(clk), .clear(cnt_clear), .en(bx_wrap), .max_val(nby_m1),
      .count(by_cnt), .wrap(by_wrap)
   );

   // BLK is a power of two, so block*BLK + offset is a plain concatenation.
   assign raw_r = {by_cnt, py_cnt};
   assign raw_c = {bx_cnt, px_cnt};
   assign h_m1  = h_lat - 1'b1;
   assign w_m1  = w_lat - 1'b1;

   always_comb begin
      addr_valid    = 1'b0;
      row           = '0;
      col           = '0;
      last_in_block = 1'b0;
      last_in_frame = 1'b0;
      frame_done    = (state == DONE);
      busy          = (state == SCAN);
      if (state == SCAN) begin
         addr_valid    = 1'b1;
         row           = (raw_r > h_m1) ? h_m1 : raw_r;
         col           = (raw_c > w_m1) ? w_m1 : raw_c;
         last_in_block = (px_cnt == PIX_MAX) && (py_cnt == PIX_MAX);
         last_in_frame = last_in_block && (bx_cnt == nbx_m1) && (by_cnt == nby_m1);
      end
   end

endmodule

// File: tb/tb_j_block_scan_addr.sv
// Directed bench for j_block_scan_addr: table of frame scans plus clear/ignore/large-image sequences.
module tb_j_block_scan_addr;

   logic        clk = 1'b0;
   logic        clear;
   logic        start;
   logic [12:0] img_width, img_height;
   logic        addr_ready;
   logic        addr_valid;
   logic [12:0] row, col;
   logic        last_in_block, last_in_frame, frame_done, busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   j_block_scan_addr dut (
      .clk(clk), .clear(clear), .start(start),
      .img_width(img_width), .img_height(img_height),
      .addr_ready(addr_ready), .addr_valid(addr_valid),
      .row(row), .col(col),
      .last_in_block(last_in_block), .last_in_frame(last_in_frame),
      .frame_done(frame_done), .busy(busy)
   );

   typedef struct {
      int w;
      int h;
      bit bp;
      bit noisy;
      int exp_addrs;
      int exp_blocks;
   } frame_vec_t;

   frame_vec_t vecs[6];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_valid"}, addr_valid, 0);
      chk({tag, "_row"}, row, 0);
      chk({tag, "_col"}, col, 0);
      chk({tag, "_lib"}, last_in_block, 0);
      chk({tag, "_lif"}, last_in_frame, 0);
      chk({tag, "_done"}, frame_done, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   // Called at a negedge while IDLE; returns at a negedge while IDLE after the frame.
   task automatic run_frame(input frame_vec_t v);
      int nbx, nby, er, ec, elib, elif, stalls;
      int n_addr, n_lib, n_lif;
      nbx = (v.w + 7) / 8;
      nby = (v.h + 7) / 8;
      n_addr = 0; n_lib = 0; n_lif = 0;
      img_width  = 13'(v.w);
      img_height = 13'(v.h);
      start      = 1'b1;
      addr_ready = 1'b0;
      @(negedge clk);
      if (v.noisy) begin
         img_width  = 13'd16;
         img_height = 13'd16;
      end else begin
         start = 1'b0;
      end
      for (int bby = 0; bby < nby; bby++)
         for (int bbx = 0; bbx < nbx; bbx++)
            for (int ppy = 0; ppy < 8; ppy++)
               for (int ppx = 0; ppx < 8; ppx++) begin
                  er   = (bby*8 + ppy > v.h - 1) ? v.h - 1 : bby*8 + ppy;
                  ec   = (bbx*8 + ppx > v.w - 1) ? v.w - 1 : bbx*8 + ppx;
                  elib = (ppx == 7 && ppy == 7) ? 1 : 0;
                  elif = (elib == 1 && bbx == nbx-1 && bby == nby-1) ? 1 : 0;
                  stalls = v.bp ? ((elif == 1) ? 3 : int'($urandom_range(0, 1))) : 0;
                  for (int s = 0; s <= stalls; s++) begin
                     addr_ready = (s == stalls);
                     chk("scan_valid", addr_valid, 1);
                     chk("scan_row", row, er);
                     chk("scan_col", col, ec);
                     chk("scan_lib", last_in_block, elib);
                     chk("scan_lif", last_in_frame, elif);
                     chk("scan_busy", busy, 1);
                     chk("scan_done", frame_done, 0);
                     if (s == stalls) begin
                        n_addr++;
                        n_lib += int'(last_in_block);
                        n_lif += int'(last_in_frame);
                     end
                     @(negedge clk);
                  end
               end
      addr_ready = 1'b0;
      start      = 1'b0;
      chk("done_pulse", frame_done, 1);
      chk("done_busy", busy, 0);
      chk("done_valid", addr_valid, 0);
      @(negedge clk);
      chk("done_one_cycle", frame_done, 0);
      chk("frame_addrs", n_addr, v.exp_addrs);
      chk("frame_blocks", n_lib, v.exp_blocks);
      chk("frame_lif", n_lif, 1);
   endtask

   initial begin
      vecs[0] = '{w: 8,  h: 8,  bp: 0, noisy: 0, exp_addrs: 64,  exp_blocks: 1};
      vecs[1] = '{w: 16, h: 8,  bp: 0, noisy: 0, exp_addrs: 128, exp_blocks: 2};
      vecs[2] = '{w: 10, h: 10, bp: 0, noisy: 0, exp_addrs: 256, exp_blocks: 4};
      vecs[3] = '{w: 8,  h: 8,  bp: 1, noisy: 0, exp_addrs: 64,  exp_blocks: 1};
      vecs[4] = '{w: 8,  h: 8,  bp: 0, noisy: 1, exp_addrs: 64,  exp_blocks: 1};
      vecs[5] = '{w: 24, h: 17, bp: 0, noisy: 0, exp_addrs: 576, exp_blocks: 9};

      clear = 1'b1; start = 1'b0; addr_ready = 1'b0;
      img_width = '0; img_height = '0;
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset");
      clear = 1'b0;
      @(negedge clk);
      chk_idle_outputs("post_reset");

      for (int i = 0; i < 6; i++) run_frame(vecs[i]);

      // Zero dimensions must not start a scan.
      img_width = 13'd0; img_height = 13'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("zero_w_busy", busy, 0);
      chk("zero_w_valid", addr_valid, 0);
      img_width = 13'd8; img_height = 13'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("zero_h_busy", busy, 0);
      @(negedge clk);
      chk("zero_h_busy2", busy, 0);

      // Clear mid-scan aborts without frame_done.
      img_width = 13'd8; img_height = 13'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0; addr_ready = 1'b1;
      repeat (20) @(negedge clk);
      chk("abort_row", row, 2);
      chk("abort_col", col, 4);
      clear = 1'b1; addr_ready = 1'b0;
      @(negedge clk);
      chk_idle_outputs("abort");
      clear = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_done", frame_done, 0);
         chk("abort_idle", busy, 0);
      end
      run_frame(vecs[0]);

      // Maximum image: first address and first block crossing.
      img_width = 13'd8191; img_height = 13'd8191; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("max_valid", addr_valid, 1);
      chk("max_row0", row, 0);
      chk("max_col0", col, 0);
      addr_ready = 1'b1;
      repeat (63) @(negedge clk);
      chk("max_lib63", last_in_block, 1);
      chk("max_lif63", last_in_frame, 0);
      chk("max_row63", row, 7);
      chk("max_col63", col, 7);
      @(negedge clk);
      chk("max_row64", row, 0);
      chk("max_col64", col, 8);
      addr_ready = 1'b0;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk_idle_outputs("max_abort");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
